// File: rtl/sec_event_log.sv
// sec_event_log: violation event FIFO with drop counter and crash/lock sequencer
module sec_event_log #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        resolve_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] target_i,
  input  logic [2:0]  cause_i,
  input  logic        en_crash_i,
  input  logic        clear_i,
  output logic        evt_valid_o,
  input  logic        evt_ready_i,
  output logic [31:0] evt_pc_o,
  output logic [31:0] evt_target_o,
  output logic [2:0]  evt_cause_o,
  output logic [7:0]  drop_cnt_o,
  output logic        crash_o,
  output logic        locked_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, HOLD, LOCKED} state_e;
  logic [66:0]   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    drop_q, drop_d;
  logic [3:0]    hold_q, hold_d;
  state_e        state_q, state_d;
  logic          ev, empty, full, pop, push, drop;
  assign ev    = resolve_valid_i & |cause_i;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign pop   = ~empty & evt_ready_i;
  // a pop frees the slot being written, so a full FIFO still accepts
  assign push  = ev & (~full | pop);
  assign drop  = ev & full & ~pop;
  always_comb begin
    wr_ptr_d = clear_i ? '0 : wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = clear_i ? '0 : rd_ptr_q + {{AW{1'b0}}, pop};
    drop_d   = clear_i ? '0 : (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {pc_i, target_i, cause_i};
  end
  assign {evt_pc_o, evt_target_o, evt_cause_o} = mem_q[rd_ptr_q[AW-1:0]];
  assign evt_valid_o = ~empty;
  assign drop_cnt_o  = drop_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
  // hold_q counts remaining HOLD cycles after the current one
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (clear_i) begin
      state_d = IDLE;
      hold_d  = '0;
    end else if (state_q == IDLE && ev && en_crash_i) begin
      state_d = HOLD;
      hold_d  = 4'(HOLD_CYCLES - 1);
    end else if (state_q == HOLD) begin
      if (hold_q == 4'd0) state_d = LOCKED;
      else hold_d = hold_q - 4'd1;
    end
  end
  always_comb begin
    crash_o  = state_q == HOLD;
    locked_o = state_q == LOCKED;
  end
endmodule

// File: tb/tb_sec_event_log.sv
// tb_sec_event_log: scoreboard bench for the event FIFO, drop counter and crash sequencer
module tb_sec_event_log;
  localparam int DEPTH = 8;
  localparam int HOLD  = 4;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        resolve_valid_i, en_crash_i, clear_i, evt_ready_i;
  logic [31:0] pc_i, target_i;
  logic [2:0]  cause_i;
  logic        evt_valid_o, crash_o, locked_o;
  logic [31:0] evt_pc_o, evt_target_o;
  logic [2:0]  evt_cause_o;
  logic [7:0]  drop_cnt_o;
  int          total = 0, bad = 0;
  int          mdrop = 0, mstate = 0, mhold = 0, crash_seen = 0;
  logic [66:0] sb [$];
  always #5 clk_i = ~clk_i;
  sec_event_log #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .resolve_valid_i(resolve_valid_i), .pc_i(pc_i),
    .target_i(target_i), .cause_i(cause_i), .en_crash_i(en_crash_i), .clear_i(clear_i),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_pc_o(evt_pc_o),
    .evt_target_o(evt_target_o), .evt_cause_o(evt_cause_o), .drop_cnt_o(drop_cnt_o),
    .crash_o(crash_o), .locked_o(locked_o)
  );
  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  // drive one cycle from just after a falling edge, check, then advance the model
  task automatic cyc(input logic rv, input logic [31:0] pc, input logic [31:0] tg,
                     input logic [2:0] c, input logic en, input logic rdy, input logic clr);
    logic ev;
    resolve_valid_i = rv; pc_i = pc; target_i = tg; cause_i = c;
    en_crash_i = en; evt_ready_i = rdy; clear_i = clr;
    #2;
    check("valid", evt_valid_o, sb.size() != 0);
    check("drop", drop_cnt_o, mdrop);
    check("crash", crash_o, mstate == 1);
    check("locked", locked_o, mstate == 2);
    if (crash_o) crash_seen++;
    if (sb.size() != 0 && rdy) check("data", {evt_pc_o, evt_target_o, evt_cause_o}, sb.pop_front());
    ev = rv && c != 3'b000;
    if (clr) begin
      sb.delete(); mdrop = 0; mstate = 0; mhold = 0;
    end else begin
      if (ev) begin
        if (sb.size() < DEPTH) sb.push_back({pc, tg, c});
        else if (mdrop < 255) mdrop++;
      end
      if (mstate == 1) begin
        mhold--;
        if (mhold == 0) mstate = 2;
      end else if (mstate == 0 && ev && en) begin
        mstate = 1; mhold = HOLD;
      end
    end
    @(negedge clk_i);
  endtask
  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 3'b111, 1'b1, rdy, 1'b0);
  endtask
  initial begin
    rst_ni = 1'b0; resolve_valid_i = 1'b0; pc_i = '0; target_i = '0; cause_i = '0;
    en_crash_i = 1'b0; clear_i = 1'b0; evt_ready_i = 1'b0;
    #1;
    check("rst_valid", evt_valid_o, 1'b0);
    check("rst_drop", drop_cnt_o, 8'd0);
    check("rst_crash", crash_o, 1'b0);
    check("rst_locked", locked_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    // single logged event, no crash
    cyc(1'b1, 32'h8000_0100, 32'h0000_1234, 3'b001, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 3);
    // fill past capacity, then push+pop while full
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h1000 + i, 32'h2000 + i, 3'(i % 7 + 1), 1'b0, 1'b0, 1'b0);
    check("fill_drop", drop_cnt_o, 8'd2);
    cyc(1'b1, 32'hAAAA_0000, 32'hBBBB_0000, 3'b100, 1'b0, 1'b1, 1'b0);
    check("full_kept", evt_valid_o, 1'b1);
    check("full_drop", drop_cnt_o, 8'd2);
    idle(1'b1, 9);
    check("drained", evt_valid_o, 1'b0);
    // crash sequence with a second event during HOLD
    crash_seen = 0;
    cyc(1'b1, 32'h3000, 32'h3004, 3'b010, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 2);
    cyc(1'b1, 32'h3100, 32'h3104, 3'b110, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 4);
    check("crash_len", crash_seen, HOLD);
    check("locked_now", locked_o, 1'b1);
    cyc(1'b1, 32'h3200, 32'h3204, 3'b001, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 2);
    check("locked_stays", locked_o, 1'b1);
    // clear beats a same-cycle event
    cyc(1'b1, 32'h3300, 32'h3304, 3'b011, 1'b1, 1'b0, 1'b1);
    check("clr_valid", evt_valid_o, 1'b0);
    check("clr_locked", locked_o, 1'b0);
    idle(1'b1, 2);
    // reset during HOLD cycle 2
    cyc(1'b1, 32'h4000, 32'h4004, 3'b100, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1);
    resolve_valid_i = 1'b0;
    #2;
    check("hold2_crash", crash_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("arst_crash", crash_o, 1'b0);
    check("arst_locked", locked_o, 1'b0);
    check("arst_valid", evt_valid_o, 1'b0);
    sb.delete(); mdrop = 0; mstate = 0; mhold = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(1'b1, 6);
    // mixed random traffic
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0));
    idle(1'b1, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
